// File: rtl/clk_pkg.sv
// Shared definitions for the digital clock counters: hour limits, the hour type
// and a binary-to-BCD helper used by the hour/minute/second stages.
package clk_pkg;

  localparam int HR_MAX  = 23;
  localparam int HR_NOON = 12;

  typedef logic [4:0] hr_t;

  // Two-digit BCD for values 0..99; tens in [7:4], ones in [3:0].
  function automatic logic [7:0] bin2bcd8(input logic [6:0] bin);
    logic [7:0] wide;
    wide = {1'b0, bin};
    return {4'(wide / 8'd10), 4'(wide % 8'd10)};
  endfunction

endpackage

// File: rtl/hr_disp_encode.sv
// Combinational display encoder: maps a 0..23 hour to 24-h or 12-h form,
// binary or BCD, zero-extended to OUT_W, plus the pm flag.
module hr_disp_encode
  import clk_pkg::*;
#(
  parameter int BCD_OUT = 0,
  parameter int OUT_W   = 8
) (
  input  logic             mode_12h,
  input  hr_t              hr,
  output logic [OUT_W-1:0] hr_out,
  output logic             pm
);

  hr_t disp;

  always_comb begin
    disp = hr;
    if (mode_12h) begin
      if (hr == 5'd0) begin
        disp = 5'(HR_NOON);
      end else if (hr > 5'(HR_NOON)) begin
        disp = hr - 5'(HR_NOON);
      end
    end
  end

  always_comb begin
    pm = (hr >= 5'(HR_NOON));
    if (BCD_OUT != 0) begin
      hr_out = OUT_W'(bin2bcd8({2'b00, disp}));
    end else begin
      hr_out = OUT_W'(disp);
    end
  end

endmodule

// File: rtl/clk_count_hr_gen.sv
// Hour counter 0..23 with up/down count, direct load, synchronous clear,
// registered 12/24-h display encoding and day carry/borrow pulses.
module clk_count_hr_gen
  import clk_pkg::*;
#(
  parameter int BCD_OUT = 0,
  parameter int OUT_W   = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             rst_counters,
  input  logic             mode_12h,
  input  logic             count_up_hr,
  input  logic             count_dn_hr,
  input  logic             load_en,
  input  logic [4:0]       load_val,
  output logic [OUT_W-1:0] hr_out,
  output logic             pm,
  output logic             day_carry,
  output logic             day_borrow,
  output logic             load_err
);

  generate
    if ((BCD_OUT == 0 && OUT_W < 5) || (BCD_OUT != 0 && OUT_W < 8)) begin : g_bad_width
      $error("clk_count_hr_gen: OUT_W too small for the selected encoding");
    end
  endgenerate

  hr_t              hr_q;
  hr_t              hr_next;
  logic             carry_next;
  logic             borrow_next;
  logic             err_next;
  logic [OUT_W-1:0] hr_out_next;
  logic             pm_next;

  // Priority: clear, load, conflicting counts, up, down, hold.
  always_comb begin
    hr_next     = hr_q;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    err_next    = 1'b0;
    if (rst_counters) begin
      hr_next = 5'd0;
    end else if (load_en) begin
      if (load_val > 5'(HR_MAX)) begin
        err_next = 1'b1;
      end else begin
        hr_next = load_val;
      end
    end else if (count_up_hr && count_dn_hr) begin
      hr_next = hr_q;
    end else if (count_up_hr) begin
      if (hr_q == 5'(HR_MAX)) begin
        hr_next    = 5'd0;
        carry_next = 1'b1;
      end else begin
        hr_next = hr_q + 5'd1;
      end
    end else if (count_dn_hr) begin
      if (hr_q == 5'd0) begin
        hr_next     = 5'(HR_MAX);
        borrow_next = 1'b1;
      end else begin
        hr_next = hr_q - 5'd1;
      end
    end
  end

  // Encoding the next state keeps hr_out aligned with hr_q on the same edge.
  hr_disp_encode #(
    .BCD_OUT (BCD_OUT),
    .OUT_W   (OUT_W)
  ) u_hr_disp_encode (
    .mode_12h (mode_12h),
    .hr       (hr_next),
    .hr_out   (hr_out_next),
    .pm       (pm_next)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      hr_q       <= 5'd0;
      hr_out     <= '0;
      pm         <= 1'b0;
      day_carry  <= 1'b0;
      day_borrow <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      hr_q       <= hr_next;
      hr_out     <= hr_out_next;
      pm         <= pm_next;
      day_carry  <= carry_next;
      day_borrow <= borrow_next;
      load_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_clk_count_hr_gen.sv
// Scoreboard bench: a binary and a BCD instance share stimulus; a behavioural
// hour model queues expected outputs and a monitor compares them every cycle.
module tb_clk_count_hr_gen;

  logic       CLK;
  logic       rst;
  logic       rst_counters;
  logic       mode_12h;
  logic       count_up_hr;
  logic       count_dn_hr;
  logic       load_en;
  logic [4:0] load_val;

  logic [7:0] hr_out_b, hr_out_d;
  logic       pm_b, pm_d, carry_b, carry_d, borrow_b, borrow_d, err_b, err_d;

  clk_count_hr_gen #(.BCD_OUT(0), .OUT_W(8)) u_dut_bin (
    .CLK(CLK), .rst(rst), .rst_counters(rst_counters), .mode_12h(mode_12h),
    .count_up_hr(count_up_hr), .count_dn_hr(count_dn_hr), .load_en(load_en),
    .load_val(load_val), .hr_out(hr_out_b), .pm(pm_b), .day_carry(carry_b),
    .day_borrow(borrow_b), .load_err(err_b)
  );

  clk_count_hr_gen #(.BCD_OUT(1), .OUT_W(8)) u_dut_bcd (
    .CLK(CLK), .rst(rst), .rst_counters(rst_counters), .mode_12h(mode_12h),
    .count_up_hr(count_up_hr), .count_dn_hr(count_dn_hr), .load_en(load_en),
    .load_val(load_val), .hr_out(hr_out_d), .pm(pm_d), .day_carry(carry_d),
    .day_borrow(borrow_d), .load_err(err_d)
  );

  typedef struct {
    int bin;
    int bcd;
    bit pm;
    bit carry;
    bit borrow;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  int   m_hr;
  int   checks;
  int   failures;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply one request to the hour and queue what both DUTs must show.
  task automatic drive(input bit up, input bit dn, input bit ld, input int lv,
                       input bit clr, input bit m12);
    exp_t e;
    int   d;
    count_up_hr  = up;
    count_dn_hr  = dn;
    load_en      = ld;
    load_val     = 5'(lv);
    rst_counters = clr;
    mode_12h     = m12;
    e.carry  = 0;
    e.borrow = 0;
    e.err    = 0;
    if (clr) m_hr = 0;
    else if (ld) begin
      if (lv <= 23) m_hr = lv;
      else e.err = 1;
    end else if (up && dn) begin
      m_hr = m_hr;
    end else if (up) begin
      if (m_hr == 23) begin m_hr = 0; e.carry = 1; end
      else m_hr = m_hr + 1;
    end else if (dn) begin
      if (m_hr == 0) begin m_hr = 23; e.borrow = 1; end
      else m_hr = m_hr - 1;
    end
    d = m12 ? ((m_hr % 12 == 0) ? 12 : m_hr % 12) : m_hr;
    e.bin = d;
    e.bcd = (d / 10) * 16 + (d % 10);
    e.pm  = (m_hr >= 12);
    sb_q.push_back(e);
  endtask

  task automatic step(input bit up, input bit dn, input bit ld, input int lv,
                      input bit clr, input bit m12);
    @(negedge CLK);
    drive(up, dn, ld, lv, clr, m12);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hr_bin"}, int'(hr_out_b), 0);
    chk({tag, "_hr_bcd"}, int'(hr_out_d), 0);
    chk({tag, "_pm"}, int'(pm_b | pm_d), 0);
    chk({tag, "_carry"}, int'(carry_b | carry_d), 0);
    chk({tag, "_borrow"}, int'(borrow_b | borrow_d), 0);
    chk({tag, "_err"}, int'(err_b | err_d), 0);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (!rst && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("hr_out_bin", int'(hr_out_b), e.bin);
      chk("hr_out_bcd", int'(hr_out_d), e.bcd);
      chk("pm_bin", int'(pm_b), int'(e.pm));
      chk("pm_bcd", int'(pm_d), int'(e.pm));
      chk("day_carry", int'(carry_b), int'(e.carry));
      chk("day_carry_bcd", int'(carry_d), int'(e.carry));
      chk("day_borrow", int'(borrow_b), int'(e.borrow));
      chk("day_borrow_bcd", int'(borrow_d), int'(e.borrow));
      chk("load_err", int'(err_b), int'(e.err));
      chk("load_err_bcd", int'(err_d), int'(e.err));
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    m_hr         = 0;
    rst          = 1'b1;
    rst_counters = 1'b0;
    mode_12h     = 1'b1;
    count_up_hr  = 1'b0;
    count_dn_hr  = 1'b0;
    load_en      = 1'b0;
    load_val     = 5'd0;

    repeat (3) @(posedge CLK);
    #2 chk_all_zero("reset");
    // Release with 12-h mode active: output stays 0 until the first edge, then 12.
    @(negedge CLK);
    rst = 1'b0;
    #1 chk("post_release_hr", int'(hr_out_b), 0);
    drive(0, 0, 0, 0, 0, 1);

    // 24 up-counts in 24-h mode, wrapping 23 -> 0 with a carry.
    for (int i = 0; i < 24; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // 12-h loads.
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 12, 0, 1);
    step(0, 0, 1, 13, 0, 1);
    step(0, 0, 1, 23, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Down-wrap from 0 and a plain decrement.
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Illegal load holds with load_err; load beats a simultaneous count.
    step(0, 0, 1, 7, 0, 0);
    step(0, 0, 1, 24, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 31, 0, 0);
    step(1, 0, 1, 5, 0, 0);

    // Clear beats count at 23; conflicting counts hold.
    step(0, 0, 1, 23, 0, 0);
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 23, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle at 15.
    step(0, 0, 1, 15, 0, 1);
    @(posedge CLK);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    sb_q.delete();
    m_hr = 0;
    @(negedge CLK);
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);

    // Randomised mix.
    for (int i = 0; i < 400; i++) begin
      int r;
      bit up, dn, ld, clr;
      r   = int'($urandom_range(0, 99));
      clr = (r < 4);
      ld  = (r >= 4 && r < 16);
      up  = ($urandom_range(0, 99) < 55);
      dn  = ($urandom_range(0, 99) < 30);
      step(up, dn, ld, int'($urandom_range(0, 31)), clr, bit'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0, 0);

    @(negedge CLK);
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
